// File: rtl/dct_sched_pkg.sv
// Shared definitions for the dct_vecrot_sched frame scheduler:
// FSM state encoding, legal frame-size bounds and the frame-size check.
package dct_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XFER      = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

  localparam logic [11:0] FFTPTS_MIN = 12'd8;
  localparam logic [11:0] FFTPTS_MAX = 12'd2048;

  // A frame size is usable by the rotation stage only if it is a power of two
  // inside [FFTPTS_MIN, FFTPTS_MAX]; zero is excluded by the lower bound.
  function automatic logic fftpts_legal(input logic [11:0] n);
    logic pow2;
    pow2 = ((n & (n - 12'd1)) == 12'd0);
    return pow2 && (n >= FFTPTS_MIN) && (n <= FFTPTS_MAX);
  endfunction

endpackage

// File: rtl/dct_sched_rr_arb.sv
// Two-way round-robin arbiter used by dct_vecrot_sched to pick which
// upstream stream gets the next whole frame.
module dct_sched_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_grant;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dct_vecrot_sched.sv
// Frame scheduler in front of dct_vecRot_ram: grants one whole frame at a
// time to one of two upstream streams (round robin), latches and validates
// the frame size, enforces frame length, counts completed frames and keeps
// sticky error flags.
// Optional feature: define DCT_SCHED_TIMEOUT_EN to add a WAIT_DONE watchdog.
module dct_vecrot_sched #(
  parameter int wDataIn     = 28,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n_sync,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_sop,
  input  logic               req0_eop,
  input  logic [wDataIn-1:0] req0_real,
  input  logic [wDataIn-1:0] req0_imag,
  input  logic [11:0]        req0_fftpts,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_sop,
  input  logic               req1_eop,
  input  logic [wDataIn-1:0] req1_real,
  input  logic [wDataIn-1:0] req1_imag,
  input  logic [11:0]        req1_fftpts,
  output logic               dn_valid,
  output logic               dn_sop,
  output logic               dn_eop,
  input  logic               dn_ready,
  output logic [wDataIn-1:0] dn_real,
  output logic [wDataIn-1:0] dn_imag,
  output logic [11:0]        dn_fftpts,
  input  logic               done_eop,
  output logic               grant_id,
  output logic               busy,
  output logic [15:0]        frame_cnt0,
  output logic [15:0]        frame_cnt1,
  output logic               err_fftpts,
  output logic               err_len,
  output logic               err_timeout
);

  import dct_sched_pkg::*;

  sched_state_e state_q, state_d;
  logic         grant_id_q, grant_id_d;
  logic         last_grant_q, last_grant_d;
  logic [11:0]  dn_fftpts_q, dn_fftpts_d;
  logic [11:0]  beat_q, beat_d;
  logic         bad_fft_q, bad_fft_d;     // FLUSH entered because of an illegal size
  logic [15:0]  frame_cnt0_q, frame_cnt0_d;
  logic [15:0]  frame_cnt1_q, frame_cnt1_d;
  logic         err_fftpts_q, err_fftpts_d;
  logic         err_len_q, err_len_d;

  logic               sel_valid;
  logic               sel_eop;
  logic [wDataIn-1:0] sel_real;
  logic [wDataIn-1:0] sel_imag;
  logic [11:0]        cand_fftpts;
  logic               gnt_valid;
  logic               gnt_id;
  logic               beat_first;
  logic               beat_last;
  logic               xfer_hs;

`ifdef DCT_SCHED_TIMEOUT_EN
  localparam int                WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_timeout_q, err_timeout_d;
`endif

  dct_sched_rr_arb u_arb (
    .req        ({req1_valid & req1_sop, req0_valid & req0_sop}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Route the granted requester's stream and the candidate frame size.
  always_comb begin
    if (grant_id_q) begin
      sel_valid = req1_valid;
      sel_eop   = req1_eop;
      sel_real  = req1_real;
      sel_imag  = req1_imag;
    end else begin
      sel_valid = req0_valid;
      sel_eop   = req0_eop;
      sel_real  = req0_real;
      sel_imag  = req0_imag;
    end
    if (gnt_id) begin
      cand_fftpts = req1_fftpts;
    end else begin
      cand_fftpts = req0_fftpts;
    end
  end

  assign beat_first = (beat_q == 12'd0);
  assign beat_last  = (beat_q == (dn_fftpts_q - 12'd1));
  assign xfer_hs    = (state_q == ST_XFER) && sel_valid && dn_ready;

  // Per-state handshake and downstream drive; data passes through with no latency in XFER.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dn_valid   = 1'b0;
    dn_sop     = 1'b0;
    dn_eop     = 1'b0;
    dn_real    = '0;
    dn_imag    = '0;
    case (state_q)
      ST_IDLE: begin
        // Stray mid-frame beats are swallowed; SOP beats are held until granted.
        req0_ready = rst_n_sync & req0_valid & ~req0_sop;
        req1_ready = rst_n_sync & req1_valid & ~req1_sop;
      end
      ST_XFER: begin
        dn_valid = sel_valid;
        dn_sop   = sel_valid & beat_first;
        dn_eop   = sel_valid & (sel_eop | beat_last);
        dn_real  = sel_real;
        dn_imag  = sel_imag;
        if (grant_id_q) begin
          req1_ready = dn_ready;
        end else begin
          req0_ready = dn_ready;
        end
      end
      ST_FLUSH: begin
        if (grant_id_q) begin
          req1_ready = 1'b1;
        end else begin
          req0_ready = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase
  end

  // Next-state, frame bookkeeping and sticky error logic.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    dn_fftpts_d  = dn_fftpts_q;
    beat_d       = beat_q;
    bad_fft_d    = bad_fft_q;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;
    err_fftpts_d = err_fftpts_q;
    err_len_d    = err_len_q;
`ifdef DCT_SCHED_TIMEOUT_EN
    err_timeout_d = err_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_id_d = gnt_id;
          beat_d     = 12'd0;
          if (fftpts_legal(cand_fftpts)) begin
            dn_fftpts_d = cand_fftpts;
            bad_fft_d   = 1'b0;
            state_d     = ST_XFER;
          end else begin
            // Keep the previous size on dn_fftpts; the bad frame is drained.
            err_fftpts_d = 1'b1;
            bad_fft_d    = 1'b1;
            state_d      = ST_FLUSH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (xfer_hs) begin
          beat_d = beat_q + 12'd1;
          if (sel_eop) begin
            if (!beat_last) begin
              err_len_d = 1'b1;
            end else begin
              err_len_d = err_len_q;
            end
            state_d = ST_WAIT_DONE;
          end else if (beat_last) begin
            // Frame hit its declared length without EOP: cut it and drain the rest.
            err_len_d = 1'b1;
            bad_fft_d = 1'b0;
            state_d   = ST_FLUSH;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_FLUSH: begin
        if (sel_valid && sel_eop) begin
          if (bad_fft_q) begin
            // Nothing reached the stage; rotate priority so the other side is not starved.
            last_grant_d = grant_id_q;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_WAIT_DONE: begin
        if (done_eop) begin
          if (grant_id_q) begin
            frame_cnt1_d = frame_cnt1_q + 16'd1;
          end else begin
            frame_cnt0_d = frame_cnt0_q + 16'd1;
          end
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
`ifdef DCT_SCHED_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          err_timeout_d = 1'b1;
          last_grant_d  = grant_id_q;
          state_d       = ST_IDLE;
`endif
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef DCT_SCHED_TIMEOUT_EN
  // Watchdog counts consecutive WAIT_DONE cycles and restarts on any exit.
  always_comb begin
    if ((state_q == ST_WAIT_DONE) && (state_d == ST_WAIT_DONE)) begin
      wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wd_d = '0;
    end
  end
`endif

  // All control state, including the watchdog when present, in one register bank.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      dn_fftpts_q  <= 12'd0;
      beat_q       <= 12'd0;
      bad_fft_q    <= 1'b0;
      frame_cnt0_q <= 16'd0;
      frame_cnt1_q <= 16'd0;
      err_fftpts_q <= 1'b0;
      err_len_q    <= 1'b0;
`ifdef DCT_SCHED_TIMEOUT_EN
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      dn_fftpts_q  <= dn_fftpts_d;
      beat_q       <= beat_d;
      bad_fft_q    <= bad_fft_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
      err_fftpts_q <= err_fftpts_d;
      err_len_q    <= err_len_d;
`ifdef DCT_SCHED_TIMEOUT_EN
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign grant_id   = grant_id_q;
  assign busy       = (state_q != ST_IDLE);
  assign dn_fftpts  = dn_fftpts_q;
  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;
  assign err_fftpts = err_fftpts_q;
  assign err_len    = err_len_q;

`ifdef DCT_SCHED_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  // Without the watchdog WAIT_DONE never gives up, so this flag can never fire.
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule
